// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache access arbiter.
package cache_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear first, otherwise step unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_access_arbiter.sv
// Two-port round-robin sequencer in front of the set-associative cache.
// The winning request is latched in IDLE and held on the cache port until
// the cache reports a hit, so miss/write-back handling sees stable inputs.
module cache_access_arbiter
  import cache_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  p0_req,
  input  logic                  p1_req,
  input  logic                  p0_we,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p0_done,
  output logic                  p1_done,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  cache_mem_en,
  output logic                  cache_we,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_din,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_dout,
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  access_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  first_q, first_d;
  logic                  sel_q, sel_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  p0_done_q, p0_done_d;
  logic                  p1_done_q, p1_done_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;

  logic p0_elig;
  logic p1_elig;
  logic grant;
  logic busy;

  // A port sitting in its own done cycle is not eligible, so a held request
  // cannot be granted twice for one transaction.
  assign p0_elig = p0_req && !p0_done_q;
  assign p1_elig = p1_req && !p1_done_q;
  assign grant   = (p0_elig && p1_elig) ? !last_q : p1_elig;
  assign busy    = (state_q == ST_BUSY);

  // Sequencer next-state: grant and latch in IDLE, wait for hit in BUSY.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    first_d    = first_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_done_d  = 1'b0;
    p1_done_d  = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (p0_elig || p1_elig) begin
          sel_d   = grant;
          last_d  = grant;
          we_d    = (grant == PORT_DATA) ? p1_we    : p0_we;
          addr_d  = (grant == PORT_DATA) ? p1_addr  : p0_addr;
          wdata_d = (grant == PORT_DATA) ? p1_wdata : p0_wdata;
          first_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cache_hit) begin
          state_d = ST_IDLE;
          if (sel_q == PORT_DATA) begin
            p1_done_d = 1'b1;
            if (!we_q) p1_rdata_d = cache_dout;
          end else begin
            p0_done_d = 1'b1;
            if (!we_q) p0_rdata_d = cache_dout;
          end
        end else begin
          first_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; last resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      first_q    <= 1'b0;
      sel_q      <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_done_q  <= 1'b0;
      p1_done_q  <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      first_q    <= first_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_done_q  <= p0_done_d;
      p1_done_q  <= p1_done_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // Address and data stay parked on the last latched values while idle.
  assign cache_mem_en = busy;
  assign cache_we     = busy && we_q;
  assign cache_addr   = addr_q;
  assign cache_din    = wdata_q;
  assign p0_done      = p0_done_q;
  assign p1_done      = p1_done_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_access_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (busy && cache_hit),
    .clr  (clr_cnt),
    .cnt  (access_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (busy && first_q && !cache_hit),
    .clr  (clr_cnt),
    .cnt  (miss_cnt)
  );

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Directed bench for cache_access_arbiter with a small behavioural cache.
module tb_cache_access_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 4;

  logic          clk;
  logic          rstn;
  logic          p0_req, p1_req, p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_done, p1_done;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          cache_mem_en, cache_we, cache_hit;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_din, cache_dout;
  logic          clr_cnt;
  logic [CW-1:0] access_cnt, miss_cnt;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  // Number of missing BUSY cycles the cache model inserts before a hit.
  int miss_cfg = 0;
  int busy_cnt;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic          written [0:(1<<AW)-1];

  cache_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .p0_req       (p0_req),
    .p1_req       (p1_req),
    .p0_we        (p0_we),
    .p1_we        (p1_we),
    .p0_addr      (p0_addr),
    .p1_addr      (p1_addr),
    .p0_wdata     (p0_wdata),
    .p1_wdata     (p1_wdata),
    .p0_done      (p0_done),
    .p1_done      (p1_done),
    .p0_rdata     (p0_rdata),
    .p1_rdata     (p1_rdata),
    .cache_mem_en (cache_mem_en),
    .cache_we     (cache_we),
    .cache_addr   (cache_addr),
    .cache_din    (cache_din),
    .cache_hit    (cache_hit),
    .cache_dout   (cache_dout),
    .clr_cnt      (clr_cnt),
    .access_cnt   (access_cnt),
    .miss_cnt     (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten locations read back a recognisable per-address pattern.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    if (a == 10'h010) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {22'd0, a};
  endfunction

  assign cache_hit  = cache_mem_en && (busy_cnt >= miss_cfg);
  assign cache_dout = written[cache_addr] ? mem[cache_addr] : pattern(cache_addr);

  // Cache model: count missing BUSY cycles and commit writes on the hit edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_cnt <= 0;
      for (int i = 0; i < (1 << AW); i++) written[i] <= 1'b0;
    end else begin
      if (cache_mem_en && !cache_hit) busy_cnt <= busy_cnt + 1;
      else busy_cnt <= 0;
      if (cache_mem_en && cache_hit && cache_we) begin
        mem[cache_addr]     <= cache_din;
        written[cache_addr] <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata);
    if (port == 1) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic releaseReq(input int port);
    if (port == 1) p1_req = 1'b0;
    else p0_req = 1'b0;
  endtask

  // Step negedges until the port's done pulse (bounded), gathering timing facts.
  task automatic waitDone(input int port, input int budget, input logic scramble,
                          input logic [AW-1:0] exp_addr, output int cycles,
                          output int busy_cycles, output logic addr_stable,
                          output logic we_at_hit);
    logic done_seen;
    cycles = 0; busy_cycles = 0; addr_stable = 1'b1; we_at_hit = 1'b0;
    done_seen = 1'b0;
    while (!done_seen && cycles <= budget) begin
      @(negedge clk);
      cycles++;
      if (cache_mem_en) begin
        busy_cycles++;
        if (cache_addr !== exp_addr) addr_stable = 1'b0;
        if (cache_hit) we_at_hit = cache_we;
      end
      if (scramble && cycles == 3) begin
        p0_addr = ~p0_addr;
        p1_addr = ~p1_addr;
      end
      done_seen = (port == 1) ? p1_done : p0_done;
    end
  endtask

  int   cyc, bcyc, grant_n, first_port, k;
  logic stable, wehit;
  int   grants [0:3];

  initial begin
    rstn = 1'b0; clr_cnt = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    repeat (2) @(negedge clk);

    checkOutput("rst_mem_en", cache_mem_en, 0);
    checkOutput("rst_we", cache_we, 0);
    checkOutput("rst_addr", cache_addr, 0);
    checkOutput("rst_din", cache_din, 0);
    checkOutput("rst_done", {p1_done, p0_done}, 0);
    checkOutput("rst_p0_rdata", p0_rdata, 0);
    checkOutput("rst_p1_rdata", p1_rdata, 0);
    checkOutput("rst_cnts", {access_cnt, miss_cnt}, 0);
    rstn = 1'b1;

    $display("[TB] single read hit");
    miss_cfg = 0;
    applyStimulus(0, 1'b0, 10'h010, 32'h0);
    waitDone(0, 20, 1'b0, 10'h010, cyc, bcyc, stable, wehit);
    checkOutput("hit_latency", cyc, 2);
    checkOutput("hit_busy_cycles", bcyc, 1);
    checkOutput("hit_rdata", p0_rdata, 32'hDEADBEEF);
    checkOutput("hit_access_cnt", access_cnt, 1);
    checkOutput("hit_miss_cnt", miss_cnt, 0);
    releaseReq(0);
    @(negedge clk);
    checkOutput("hit_done_one_cycle", p0_done, 0);

    $display("[TB] read miss, 12 missing cycles, input changed mid-access");
    miss_cfg = 12;
    applyStimulus(0, 1'b0, 10'h2A0, 32'h0);
    waitDone(0, 40, 1'b1, 10'h2A0, cyc, bcyc, stable, wehit);
    checkOutput("miss_latency", cyc, 14);
    checkOutput("miss_busy_cycles", bcyc, 13);
    checkOutput("miss_addr_stable", stable, 1);
    checkOutput("miss_rdata", p0_rdata, 32'hC0DE02A0);
    checkOutput("miss_miss_cnt", miss_cnt, 1);
    checkOutput("miss_access_cnt", access_cnt, 2);
    releaseReq(0);
    miss_cfg = 0;
    @(negedge clk);

    $display("[TB] contention from reset");
    rstn = 1'b0;
    applyStimulus(0, 1'b0, 10'h020, 32'h0);
    applyStimulus(1, 1'b0, 10'h030, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    grant_n = 0;
    k = 0;
    while (grant_n < 4 && k < 20) begin
      @(negedge clk);
      k++;
      if (p0_done && p1_done) checkOutput("rr_double_done", {p1_done, p0_done}, 2'b01);
      if (p0_done) begin grants[grant_n] = 0; grant_n++; end
      else if (p1_done) begin grants[grant_n] = 1; grant_n++; end
    end
    releaseReq(0);
    releaseReq(1);
    checkOutput("rr_grant_count", grant_n, 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_grant%0d", i), grants[i], i % 2);
    checkOutput("rr_p0_rdata", p0_rdata, 32'hC0DE0020);
    checkOutput("rr_p1_rdata", p1_rdata, 32'hC0DE0030);
    @(negedge clk);

    $display("[TB] write miss then read back");
    miss_cfg = 3;
    applyStimulus(1, 1'b1, 10'h3F8, 32'h12345678);
    waitDone(1, 20, 1'b0, 10'h3F8, cyc, bcyc, stable, wehit);
    checkOutput("wr_latency", cyc, 5);
    checkOutput("wr_we_on_hit", wehit, 1);
    checkOutput("wr_rdata_kept", p1_rdata, 32'hC0DE0030);
    checkOutput("idle_mem_en", cache_mem_en, 0);
    checkOutput("idle_we", cache_we, 0);
    checkOutput("idle_addr_parked", cache_addr, 10'h3F8);
    checkOutput("idle_din_parked", cache_din, 32'h12345678);
    releaseReq(1);
    miss_cfg = 0;
    @(negedge clk);
    applyStimulus(1, 1'b0, 10'h3F8, 32'h0);
    waitDone(1, 20, 1'b0, 10'h3F8, cyc, bcyc, stable, wehit);
    checkOutput("rd_back_latency", cyc, 2);
    checkOutput("rd_back_rdata", p1_rdata, 32'h12345678);
    releaseReq(1);
    @(negedge clk);

    $display("[TB] counter clear and saturation");
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    checkOutput("clr_cnts", {access_cnt, miss_cnt}, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1'b0, 10'h040, 32'h0);
      waitDone(0, 20, 1'b0, 10'h040, cyc, bcyc, stable, wehit);
      releaseReq(0);
      @(negedge clk);
    end
    checkOutput("sat_access_cnt", access_cnt, 15);
    checkOutput("sat_miss_cnt", miss_cnt, 0);
    applyStimulus(0, 1'b0, 10'h040, 32'h0);
    @(negedge clk);
    checkOutput("clr_race_hit", cache_hit, 1);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    checkOutput("clr_race_done", p0_done, 1);
    checkOutput("clr_race_access_cnt", access_cnt, 0);
    releaseReq(0);
    @(negedge clk);

    $display("[TB] reset during miss");
    miss_cfg = 10;
    applyStimulus(0, 1'b0, 10'h0AA, 32'h0);
    bcyc = 0;
    k = 0;
    while (bcyc < 5 && k < 20) begin
      @(negedge clk);
      k++;
      if (cache_mem_en) bcyc++;
    end
    checkOutput("rstmid_reached_busy5", bcyc, 5);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rstmid_mem_en_async", cache_mem_en, 0);
    checkOutput("rstmid_addr", cache_addr, 0);
    releaseReq(0);
    miss_cfg = 0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rstmid_no_done", {p1_done, p0_done}, 0);
    end
    applyStimulus(0, 1'b0, 10'h050, 32'h0);
    applyStimulus(1, 1'b0, 10'h060, 32'h0);
    rstn = 1'b1;
    first_port = -1;
    cyc = 0;
    while (first_port < 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (p0_done) first_port = 0;
      else if (p1_done) first_port = 1;
    end
    releaseReq(0);
    releaseReq(1);
    checkOutput("rstmid_first_winner", first_port, 0);
    checkOutput("rstmid_first_latency", cyc, 2);
    checkOutput("rstmid_p0_rdata", p0_rdata, 32'hC0DE0050);
    checkOutput("rstmid_p1_rdata", p1_rdata, 0);
    checkOutput("rstmid_cnts", {access_cnt, miss_cnt}, {4'd1, 4'd0});
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/cache_access_arbiter.md
# cache_access_arbiter

Sequencer and two-port arbiter placed in front of `cache_set_associative`. It shares the single cache port between an instruction-fetch requester (port 0) and a data requester (port 1). It holds address, data and write-enable stable for the whole miss/write-back sequence, as the cache requires. It returns read data with a one-cycle `done` pulse and keeps hit/miss performance counters.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: word width; matches the cache.
- `ADDR_WIDTH`, default 10: word address width; matches the cache.
- `CNT_WIDTH`, default 16: width of the saturating performance counters.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` input 1: level request; held until the matching `done`.
- `p0_we`, `p1_we` input 1: 1 = write, 0 = read; stable while `req` is high.
- `p0_addr`, `p1_addr` input ADDR_WIDTH: word address; stable while `req` is high.
- `p0_wdata`, `p1_wdata` input DATA_WIDTH: write data.
- `p0_done`, `p1_done` output 1: one-cycle completion pulse.
- `p0_rdata`, `p1_rdata` output DATA_WIDTH: registered read data; valid when `done` is high and held until the next completion on that port.
- `cache_mem_en` output 1: drives the cache `mem_en`.
- `cache_we` output 1: drives the cache `we`.
- `cache_addr` output ADDR_WIDTH: drives the cache `addr`.
- `cache_din` output DATA_WIDTH: drives the cache `din`.
- `cache_hit` input 1: combinational hit from the cache.
- `cache_dout` input DATA_WIDTH: combinational read data from the cache.
- `clr_cnt` input 1: synchronous clear of both counters.
- `access_cnt` output CNT_WIDTH: number of completed accesses, saturating.
- `miss_cnt` output CNT_WIDTH: number of accesses whose first BUSY cycle missed, saturating.

## Operation
- FSM states:
  - IDLE: `cache_mem_en`=0. If any request is eligible, latch the winner's index, `we`, `addr` and `wdata` into registers. Set `first`=1 and go to BUSY.
  - BUSY: `cache_mem_en`=1; `cache_*` outputs come from the latched registers only.
    - If `cache_hit`=1: the access completes on this edge, and the cache commits any write on the same edge. Register `cache_dout` into the winner's `rdata` (reads only; writes leave `rdata` unchanged). Assert the winner's `done` for the next cycle and return to IDLE.
    - Otherwise stay in BUSY and clear `first`.
- Eligibility: port k is eligible when `pk_req`=1 and `pk_done`=0. A requester therefore never re-issues during its own `done` cycle.
- Arbitration is round-robin via register `last`:
  - Both eligible: grant `!last`.
  - One eligible: grant it.
  - `last` is updated to the winner at grant.
- Counters, both saturating at all-ones:
  - `access_cnt` increments on each completion.
  - `miss_cnt` increments on the first BUSY cycle if `cache_hit`=0.
  - If `clr_cnt` coincides with an increment, the clear wins.
- Idle outputs: when not in BUSY, `cache_we`=0 and `cache_mem_en`=0. `cache_addr`/`cache_din` keep their last latched values, so no spurious miss handling is triggered.

## Timing
- Reset values:
  - State IDLE; `last`=1, so port 0 wins the first tie.
  - `cache_mem_en`=0, `cache_we`=0, `cache_addr`=0, `cache_din`=0.
  - `p0_done`=`p1_done`=0, `p0_rdata`=`p1_rdata`=0, `first`=0.
  - Both counters 0.
- Hit latency: request seen in IDLE at cycle 0; BUSY at cycle 1 with hit; `done` at cycle 2. The port is re-grantable at cycle 3.
- Miss latency: 2 + N cycles, where N is the number of BUSY cycles with `cache_hit`=0 (write-back plus refill).
- Throughput: one access per 2 cycles when all accesses hit.
- Input sampling: requester inputs are sampled only in IDLE; later changes are ignored until `done`.
- Reset asserted mid-BUSY: return to IDLE immediately and drop `cache_mem_en`. No `done` is issued, and the requester must re-issue. The cache is reset by the same `rstn`.
- If `cache_hit` is 1 on the first BUSY cycle, there is no miss count and completion follows the hit-latency timing above.

## Structure
- Package `cache_arb_pkg`:
  - state enum (`ST_IDLE`, `ST_BUSY`);
  - port index constants `PORT_IF`=0, `PORT_DATA`=1.
- Sub-module `sat_counter` (parameter WIDTH; inputs `inc`, `clr`; output `cnt`): instantiated twice, once per counter.
- Round-robin and latch logic stay inline.

## Test plan
- Single read, hit on first cycle: p0 reads addr 0x010; cache model hits with dout 0xDEADBEEF. Required: `p0_done` at cycle 2 with `p0_rdata`=0xDEADBEEF; access_cnt=1, miss_cnt=0.
- Read miss: cache model holds hit low for 12 BUSY cycles. Required: `cache_addr` is stable for all 13 BUSY cycles; `done` at cycle 14; miss_cnt=1.
- Contention: p0 and p1 request together from reset, and both keep re-requesting. Required: grants alternate p0, p1, p0, p1; no port gets two grants in a row.
- Write then read: p1 writes 0x12345678 to addr 0x3F8 (miss, then hit). Required: `cache_we`=1 on the hit edge; p1 `rdata` unchanged. A following p1 read of 0x3F8 returns 0x12345678.
- Counters: with CNT_WIDTH=4, run 20 hits. Required: access_cnt=15 (saturated). `clr_cnt` concurrent with a completion leaves 0.
- Reset mid-miss: assert `rstn`=0 in the 5th BUSY cycle. Required: `cache_mem_en`=0 asynchronously and no `done`. After release, p0 wins the first tie.
